// File: rtl/srl_fifo_reg_stat_pkg.sv
// srl_fifo_reg_stat_pkg: shared sizing helpers, pointer encoding and flag compare
// used by the SRL FIFO with registered first-word-fall-through output.
package srl_fifo_reg_stat_pkg;

  // Pointer value meaning "SRL holds nothing"; sliced to the pointer width,
  // it is the all-ones pattern (-1) including the extra sign bit.
  localparam logic [7:0] PTR_EMPTY = 8'hFF;

  // Width of the occupancy counter: must hold 0..DEPTH+1.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 2);
  endfunction

  // Threshold compare shared by the almost-full / almost-empty flags.
  function automatic logic level_ge(input int unsigned a, input int unsigned b);
    return (a >= b);
  endfunction

endpackage

// File: rtl/srl_fifo_reg_stat_if.sv
// srl_fifo_reg_stat_if: write/read handshake and status bundle of the FIFO.
// With SRL_FIFO_REG_STAT_ERR_EN defined, sticky overflow/underflow are added.
interface srl_fifo_reg_stat_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
);
  import srl_fifo_reg_stat_pkg::*;

  localparam int CW = cnt_width(DEPTH);

  logic             write_en;
  logic [WIDTH-1:0] write_data;
  logic             read_en;
  logic [WIDTH-1:0] read_data;
  logic             full;
  logic             empty;
  logic             almost_full;
  logic             almost_empty;
  logic [CW-1:0]    count;
`ifdef SRL_FIFO_REG_STAT_ERR_EN
  logic             overflow;
  logic             underflow;

  modport master (
    output write_en, write_data, read_en,
    input  read_data, full, empty, almost_full, almost_empty, count,
           overflow, underflow
  );
  modport slave (
    input  write_en, write_data, read_en,
    output read_data, full, empty, almost_full, almost_empty, count,
           overflow, underflow
  );
`else
  modport master (
    output write_en, write_data, read_en,
    input  read_data, full, empty, almost_full, almost_empty, count
  );
  modport slave (
    input  write_en, write_data, read_en,
    output read_data, full, empty, almost_full, almost_empty, count
  );
`endif

endinterface

// File: rtl/srl_fifo_reg_stat_srl_shift_reg.sv
// srl_shift_reg: plain addressable shift register with no reset so that the
// storage maps onto LUT shift-register primitives.
module srl_shift_reg #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     shift_en,
  input  logic [WIDTH-1:0]         din,
  input  logic [$clog2(DEPTH)-1:0] addr,
  output logic [WIDTH-1:0]         dout
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Shift a new word into entry 0, moving every entry up by one.
  always_ff @(posedge clk) begin
    if (shift_en) begin
      mem[0] <= din;
      for (int i = 1; i < DEPTH; i++) begin
        mem[i] <= mem[i-1];
      end
    end
  end

  assign dout = mem[addr];

endmodule

// File: rtl/srl_fifo_reg_stat.sv
// srl_fifo_reg_stat: SRL-based FIFO with a first-word-fall-through output
// register, occupancy count and programmable almost-full/almost-empty flags.
// Capacity is DEPTH+1 words (SRL plus output register).
// Optional macro SRL_FIFO_REG_STAT_ERR_EN adds sticky overflow/underflow.
module srl_fifo_reg_stat
  import srl_fifo_reg_stat_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2
) (
  input  logic clk,
  input  logic rst,
  srl_fifo_reg_stat_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = cnt_width(DEPTH);
  localparam logic [PW-1:0] PTR_ONE   = {{(PW-1){1'b0}}, 1'b1};
  localparam logic [PW-1:0] PTR_RESET = PTR_EMPTY[PW-1:0];
  localparam logic [CW-1:0] CNT_ONE   = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_FULL  = CW'(DEPTH + 1);

  if ((AF_LEVEL > DEPTH + 1) || (AE_LEVEL >= AF_LEVEL) ||
      (DEPTH < 4) || (DEPTH > 64) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_params
    $fatal(1, "srl_fifo_reg_stat: illegal DEPTH/AF_LEVEL/AE_LEVEL combination");
  end

  logic [PW-1:0]    ptr_r;
  logic [CW-1:0]    count_r;
  logic             out_valid_r;
  logic [WIDTH-1:0] out_data_r;
  logic             full_r;
  logic             af_r;
  logic             ae_r;

  logic             wr_acc_s;
  logic             rd_acc_s;
  logic             srl_empty_s;
  logic             out_need_s;
  logic             load_srl_s;
  logic             bypass_s;
  logic             shift_en_s;
  logic [WIDTH-1:0] srl_dout_s;
  logic [PW-1:0]    ptr_next_s;
  logic [CW-1:0]    count_next_s;

  srl_shift_reg #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_srl (
    .clk      (clk),
    .shift_en (shift_en_s),
    .din      (bus.write_data),
    .addr     (ptr_r[AW-1:0]),
    .dout     (srl_dout_s)
  );

  // Accept decisions, output-register refill source and next pointer/count.
  always_comb begin
    wr_acc_s    = bus.write_en && !full_r;
    rd_acc_s    = bus.read_en && out_valid_r;
    srl_empty_s = ptr_r[PW-1];
    out_need_s  = !out_valid_r || rd_acc_s;
    load_srl_s  = out_need_s && !srl_empty_s;
    bypass_s    = out_need_s && srl_empty_s && wr_acc_s;
    shift_en_s  = wr_acc_s && !bypass_s;
    ptr_next_s  = ptr_r;
    case ({shift_en_s, load_srl_s})
      2'b10:   ptr_next_s = ptr_r + PTR_ONE;
      2'b01:   ptr_next_s = ptr_r - PTR_ONE;
      default: ptr_next_s = ptr_r;
    endcase
    count_next_s = count_r;
    case ({wr_acc_s, rd_acc_s})
      2'b10:   count_next_s = count_r + CNT_ONE;
      2'b01:   count_next_s = count_r - CNT_ONE;
      default: count_next_s = count_r;
    endcase
  end

  // Pointer, occupancy, output register and registered flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_r       <= PTR_RESET;
      count_r     <= {CW{1'b0}};
      out_valid_r <= 1'b0;
      out_data_r  <= {WIDTH{1'b0}};
      full_r      <= 1'b0;
      af_r        <= 1'b0;
      ae_r        <= 1'b1;
    end else begin
      ptr_r   <= ptr_next_s;
      count_r <= count_next_s;
      if (out_need_s) begin
        out_valid_r <= load_srl_s || bypass_s;
      end
      if (load_srl_s) begin
        out_data_r <= srl_dout_s;
      end else if (bypass_s) begin
        out_data_r <= bus.write_data;
      end
      full_r <= (count_next_s == CNT_FULL);
      af_r   <= level_ge(int'(count_next_s), AF_LEVEL);
      ae_r   <= level_ge(AE_LEVEL, int'(count_next_s));
    end
  end

  assign bus.read_data    = out_data_r;
  assign bus.empty        = !out_valid_r;
  assign bus.full         = full_r;
  assign bus.almost_full  = af_r;
  assign bus.almost_empty = ae_r;
  assign bus.count        = count_r;

`ifdef SRL_FIFO_REG_STAT_ERR_EN
  logic overflow_r;
  logic underflow_r;

  // Sticky error flags; only reset clears them.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      overflow_r  <= overflow_r  || (bus.write_en && full_r);
      underflow_r <= underflow_r || (bus.read_en && !out_valid_r);
    end
  end

  assign bus.overflow  = overflow_r;
  assign bus.underflow = underflow_r;
`endif

endmodule

// File: tb/tb_srl_fifo_reg_stat.sv
// tb_srl_fifo_reg_stat: directed + random stimulus against a queue model of
// the FIFO; a negedge process compares every output each cycle.
module tb_srl_fifo_reg_stat;

  localparam int W   = 8;
  localparam int D   = 16;
  localparam int CAP = D + 1;
  localparam int AF  = D - 2;
  localparam int AE  = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  srl_fifo_reg_stat_if #(.WIDTH(W), .DEPTH(D)) bus ();

  srl_fifo_reg_stat #(.WIDTH(W), .DEPTH(D), .AF_LEVEL(AF), .AE_LEVEL(AE)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Reference model: a queue of held words plus the last visible head word.
  logic [W-1:0] q[$];
  logic [W-1:0] hold = '0;
  logic         m_ovf = 1'b0;
  logic         m_unf = 1'b0;

  always @(posedge clk) begin
    logic wacc, racc;
    logic [W-1:0] popped;
    if (rst) begin
      q.delete();
      hold  = '0;
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      wacc = bus.write_en && (q.size() < CAP);
      racc = bus.read_en && (q.size() > 0);
      if (bus.write_en && q.size() == CAP) m_ovf = 1'b1;
      if (bus.read_en && q.size() == 0) m_unf = 1'b1;
      if (racc) popped = q.pop_front();
      if (wacc) q.push_back(bus.write_data);
      if (q.size() > 0) hold = q[0];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of all DUT outputs against the model.
  always @(negedge clk) begin
    int n;
    n = q.size();
    chk("m_count", 32'(bus.count), 32'(n));
    chk("m_empty", 32'(bus.empty), 32'(n == 0));
    chk("m_full",  32'(bus.full),  32'(n == CAP));
    chk("m_af",    32'(bus.almost_full),  32'(!rst && n >= AF));
    chk("m_ae",    32'(bus.almost_empty), 32'(n <= AE));
    chk("m_data",  32'(bus.read_data), 32'(hold));
`ifdef SRL_FIFO_REG_STAT_ERR_EN
    chk("m_ovf", 32'(bus.overflow),  32'(m_ovf));
    chk("m_unf", 32'(bus.underflow), 32'(m_unf));
`endif
  end

  task automatic step(input logic we, input logic [W-1:0] wd, input logic re);
    bus.write_en   = we;
    bus.write_data = wd;
    bus.read_en    = re;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [W-1:0] r;
    bus.write_en = 1'b0; bus.write_data = '0; bus.read_en = 1'b0;
    rst = 1'b1;
    step(1'b0, 8'h00, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    rst = 1'b0;
    chk("rst_count", 32'(bus.count), 32'd0);
    chk("rst_empty", 32'(bus.empty), 32'd1);
    chk("rst_data",  32'(bus.read_data), 32'h00);
    chk("rst_ae",    32'(bus.almost_empty), 32'd1);

    // Single word latency and pop
    step(1'b1, 8'hA5, 1'b0);
    chk("one_empty", 32'(bus.empty), 32'd0);
    chk("one_data",  32'(bus.read_data), 32'hA5);
    chk("one_count", 32'(bus.count), 32'd1);
    step(1'b0, 8'h00, 1'b1);
    chk("pop_empty", 32'(bus.empty), 32'd1);
    chk("pop_count", 32'(bus.count), 32'd0);

    // Fill to capacity, drop an extra write, drain in order
    for (int i = 0; i < 17; i++) begin
      step(1'b1, W'(i), 1'b0);
      chk("fill_af", 32'(bus.almost_full), 32'((i + 1) >= 14));
    end
    chk("fill_full",  32'(bus.full), 32'd1);
    chk("fill_count", 32'(bus.count), 32'd17);
    step(1'b1, 8'hFF, 1'b0);
    chk("drop_count", 32'(bus.count), 32'd17);
    for (int i = 0; i < 17; i++) begin
      chk("drain_data", 32'(bus.read_data), 32'(i));
      step(1'b0, 8'h00, 1'b1);
    end
    chk("drain_empty", 32'(bus.empty), 32'd1);

    // Read while empty: no state change
    step(1'b0, 8'h00, 1'b1);
    chk("urd_count", 32'(bus.count), 32'd0);
    chk("urd_data",  32'(bus.read_data), 32'h10);

    // Steady state at count 5
    for (int i = 0; i < 5; i++) step(1'b1, W'(8'h40 + i), 1'b0);
    for (int i = 0; i < 100; i++) begin
      r = W'($urandom);
      step(1'b1, r, 1'b1);
    end
    chk("steady_count", 32'(bus.count), 32'd5);
    for (int i = 0; i < 5; i++) step(1'b0, 8'h00, 1'b1);

    // Write while full with a same-cycle read: write dropped, read taken
    for (int i = 0; i < 17; i++) step(1'b1, W'(8'h80 + i), 1'b0);
    step(1'b1, 8'hEE, 1'b1);
    chk("fullrw_count", 32'(bus.count), 32'd16);
    chk("fullrw_data",  32'(bus.read_data), 32'h81);
    for (int i = 0; i < 16; i++) step(1'b0, 8'h00, 1'b1);
    chk("fullrw_last", 32'(bus.read_data), 32'h90);
`ifdef SRL_FIFO_REG_STAT_ERR_EN
    chk("ovf_sticky", 32'(bus.overflow),  32'd1);
    chk("unf_sticky", 32'(bus.underflow), 32'd1);
`endif

    // Reset in the middle of a burst
    for (int i = 0; i < 9; i++) step(1'b1, W'(8'hC0 + i), 1'b0);
    rst = 1'b1;
    step(1'b1, 8'h55, 1'b0);
    rst = 1'b0;
    chk("mrst_count", 32'(bus.count), 32'd0);
    chk("mrst_empty", 32'(bus.empty), 32'd1);
    chk("mrst_af",    32'(bus.almost_full), 32'd0);
    chk("mrst_data",  32'(bus.read_data), 32'h00);
`ifdef SRL_FIFO_REG_STAT_ERR_EN
    chk("mrst_ovf", 32'(bus.overflow), 32'd0);
`endif
    step(1'b1, 8'h3C, 1'b0);
    chk("mrst_wr_data",  32'(bus.read_data), 32'h3C);
    chk("mrst_wr_count", 32'(bus.count), 32'd1);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      r = W'($urandom);
      step(1'($urandom_range(1, 0)), r, 1'($urandom_range(1, 0)));
    end
    step(1'b0, 8'h00, 1'b0);
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
